// File: rtl/popcnt_acc.sv
// Two-stage popcount accumulator: S1 counts one beat, S2 accumulates
// the beats of a vector and emits a clamped sum plus binarised activation.
module popcnt_acc #(
    parameter int INPUT_WIDTH   = 144,
    parameter int NUM_BEATS_MAX = 16,
    parameter int OUTPUT_WIDTH  = $clog2(INPUT_WIDTH*NUM_BEATS_MAX+1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [INPUT_WIDTH-1:0]  data_i,
    input  logic [INPUT_WIDTH-1:0]  weight_i,
    input  logic                    xnor_en_i,
    input  logic                    last_i,
    input  logic [OUTPUT_WIDTH-1:0] threshold_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [OUTPUT_WIDTH-1:0] sum_o,
    output logic                    bin_o,
    output logic                    sat_o
);

    localparam int CW = $clog2(INPUT_WIDTH+1);
    localparam int AW = OUTPUT_WIDTH + 1;

    logic                    adv;
    logic                    fire;
    logic [INPUT_WIDTH-1:0]  word;
    logic [CW-1:0]           cnt;

    logic                    s1_valid;
    logic [CW-1:0]           s1_cnt;
    logic                    s1_last;
    logic [OUTPUT_WIDTH-1:0] s1_thr;

    logic [OUTPUT_WIDTH-1:0] acc;
    logic                    sat;
    logic [AW-1:0]           acc_sum;
    logic                    over;
    logic [OUTPUT_WIDTH-1:0] clamped;

    // A stalled, unconsumed result freezes the whole pipe
    assign adv        = !(out_valid_o && !out_ready_i);
    assign in_ready_o = adv && !clear_i && rst_ni;
    assign fire       = in_valid_i && in_ready_o;

    always_comb begin
        word = xnor_en_i ? ~(data_i ^ weight_i) : data_i;
        cnt  = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            cnt = cnt + CW'(word[i]);
        end
    end

    assign acc_sum = {1'b0, acc} + AW'(s1_cnt);
    assign over    = acc_sum[OUTPUT_WIDTH];
    assign clamped = over ? '1 : acc_sum[OUTPUT_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid    <= 1'b0;
            s1_cnt      <= '0;
            s1_last     <= 1'b0;
            s1_thr      <= '0;
            acc         <= '0;
            sat         <= 1'b0;
            out_valid_o <= 1'b0;
            sum_o       <= '0;
            bin_o       <= 1'b0;
            sat_o       <= 1'b0;
        end else if (clear_i) begin
            s1_valid    <= 1'b0;
            acc         <= '0;
            sat         <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (adv) begin
            s1_valid <= fire;
            if (fire) begin
                s1_cnt  <= cnt;
                s1_last <= last_i;
                s1_thr  <= threshold_i;
            end
            out_valid_o <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    sum_o <= clamped;
                    bin_o <= (clamped >= s1_thr);
                    sat_o <= sat | over;
                    acc   <= '0;
                    sat   <= 1'b0;
                end else begin
                    acc <= clamped;
                    sat <= sat | over;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcnt_acc.sv
// Scoreboard bench for popcnt_acc: a reference model queues expected
// results on accepted last beats; the monitor pops them on handshakes.
module tb_popcnt_acc;

    localparam int IW = 8;
    localparam int NB = 4;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] data;
    logic [IW-1:0] weight;
    logic          xnor_en;
    logic          last;
    logic [OW-1:0] thr;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] sum;
    logic          bin;
    logic          sat;

    typedef struct {
        int sum;
        int bin;
        int sat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   nout = 0;
    int   macc = 0;
    bit   hold = 0;
    int   hsum = 0;
    int   st;
    int   st_sum;

    popcnt_acc #(
        .INPUT_WIDTH(IW),
        .NUM_BEATS_MAX(NB),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .clear_i(clear),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .data_i(data),
        .weight_i(weight),
        .xnor_en_i(xnor_en),
        .last_i(last),
        .threshold_i(thr),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o(sum),
        .bin_o(bin),
        .sat_o(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        logic [IW-1:0] w;
        if (hold) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_sum", int'(sum), hsum);
        end
        hold = rst_n && !clear && out_valid && !out_ready;
        hsum = int'(sum);
        if (!rst_n || clear) begin
            q.delete();
            macc = 0;
        end else begin
            if (out_valid && out_ready) begin
                nout++;
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", int'(sum), e.sum);
                    chk("bin", int'(bin), e.bin);
                    chk("sat", int'(sat), e.sat);
                end
            end
            if (in_valid && in_ready) begin
                w = xnor_en ? ~(data ^ weight) : data;
                macc += $countones(w);
                if (last) begin
                    e.sum = (macc > 63) ? 63 : macc;
                    e.bin = (e.sum >= int'(thr)) ? 1 : 0;
                    e.sat = (macc > 63) ? 1 : 0;
                    q.push_back(e);
                    macc = 0;
                end
            end
        end
    end

    task automatic send(input logic [IW-1:0] d, input logic [IW-1:0] wt,
                        input logic x, input logic l,
                        input logic [OW-1:0] t, output int stalls);
        in_valid = 1'b1;
        data     = d;
        weight   = wt;
        xnor_en  = x;
        last     = l;
        thr      = t;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        data      = '0;
        weight    = '0;
        xnor_en   = 1'b0;
        last      = 1'b0;
        thr       = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // single plain beat, latency T+2, one-cycle valid
        send(8'hB5, 8'h00, 1'b0, 1'b1, 6'd5, st);
        @(negedge clk);
        chk("lat_t1", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_t2", int'(out_valid), 1);
        chk("t1_sum", int'(sum), 5);
        @(negedge clk);
        chk("t1_pulse", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // xnor vector followed back-to-back by a plain vector
        st_sum = 0;
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 6'd9, st); st_sum += st;
        send(8'h00, 8'hFF, 1'b1, 1'b0, 6'd9, st); st_sum += st;
        send(8'hF0, 8'h0F, 1'b1, 1'b1, 6'd9, st); st_sum += st;
        send(8'h0F, 8'h00, 1'b0, 1'b0, 6'd4, st); st_sum += st;
        send(8'h33, 8'h00, 1'b0, 1'b1, 6'd4, st); st_sum += st;
        chk("no_bubble", st_sum, 0);
        idle(4);

        // backpressure while the next vector streams in
        out_ready = 1'b0;
        send(8'h0F, 8'h00, 1'b0, 1'b1, 6'd3, st);
        send(8'h07, 8'h00, 1'b0, 1'b0, 6'd6, st);
        fork
            send(8'h3F, 8'h00, 1'b0, 1'b1, 6'd6, st);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready", int'(in_ready), 0);
                    chk("bp_valid", int'(out_valid), 1);
                    chk("bp_sum", int'(sum), 4);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // saturation boundary
        for (int i = 0; i < 6; i++)
            send(8'hFF, 8'h00, 1'b0, i == 5, 6'd40, st);
        for (int i = 0; i < 8; i++)
            send(8'hFF, 8'h00, 1'b0, i == 7, 6'd63, st);
        send(8'h01, 8'h00, 1'b0, 1'b1, 6'd0, st);
        idle(4);

        // clear mid-vector
        send(8'hFF, 8'h00, 1'b0, 1'b0, 6'd1, st);
        send(8'hFF, 8'h00, 1'b0, 1'b0, 6'd1, st);
        clear    = 1'b1;
        in_valid = 1'b1;
        data     = 8'hFF;
        @(negedge clk);
        chk("clr_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        send(8'h01, 8'h00, 1'b0, 1'b1, 6'd1, st);
        idle(4);

        // reset while a result is pending
        out_ready = 1'b0;
        send(8'hFF, 8'h00, 1'b0, 1'b1, 6'd1, st);
        st = 0;
        while (!out_valid && st < 20) begin
            @(negedge clk);
            st++;
        end
        chk("r6_pending", int'(out_valid), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r6_valid", int'(out_valid), 0);
        chk("r6_sum", int'(sum), 0);
        chk("r6_bin", int'(bin), 0);
        chk("r6_sat", int'(sat), 0);
        chk("r6_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(8'h03, 8'h00, 1'b0, 1'b1, 6'd3, st);
        idle(10);

        chk("q_empty", q.size(), 0);
        chk("n_results", nout, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcnt_acc.md
# popcnt_acc

Pipelined, multi-beat popcount accumulator for the binary layers of the combinational BNN datapath. It counts the ones in a stream of INPUT_WIDTH-bit words, optionally XNORing each word with a weight word first. It accumulates the counts over a variable-length vector of beats ending with `last_i`, then returns the total and a binarised activation (sum ≥ threshold). It sits between the activation/weight fetch and the output-activation packer, and replaces the single-cycle combinational popcount where a neuron's fan-in exceeds one word.

## Interface
- `INPUT_WIDTH`, 144: bits per input beat.
- `NUM_BEATS_MAX`, 16: maximum beats per vector before saturation.
- `OUTPUT_WIDTH`, $clog2(INPUT_WIDTH*NUM_BEATS_MAX+1): width of the sum and threshold.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `clear_i`  in  1  synchronous flush of the pipeline and accumulator.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  input beat accepted when `in_valid_i && in_ready_o`.
- `data_i`  in  INPUT_WIDTH  activation bits.
- `weight_i`  in  INPUT_WIDTH  weight bits, used only when `xnor_en_i`=1.
- `xnor_en_i`  in  1  1: count `~(data_i ^ weight_i)`; 0: count `data_i`. Sampled per beat.
- `last_i`  in  1  marks the final beat of a vector.
- `threshold_i`  in  OUTPUT_WIDTH  binarisation threshold, sampled with the last beat.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  result consumed when `out_valid_o && out_ready_i`.
- `sum_o`  out  OUTPUT_WIDTH  accumulated popcount.
- `bin_o`  out  1  equals `sum_o >= threshold_i` as sampled with the last beat.
- `sat_o`  out  1  the vector exceeded the accumulator range; `sum_o` is clamped.

## Operation
- **S1 (count stage):** on an accepted beat, registers the popcount of the selected word (width $clog2(INPUT_WIDTH+1)), plus `last` and `threshold`, and sets `s1_valid`.
- **S2 (accumulate stage):** when `s1_valid`, computes `acc + s1_cnt`.
  - Non-last beat: the result is written back into `acc`.
  - Last beat: the result is written to `sum_o`, `bin_o` and `sat_o` are computed, `out_valid_o` is set, and `acc` is reset to 0.
- The next vector's beats may follow the last beat back-to-back with no bubble.
- **Advance:** `adv = !(out_valid_o && !out_ready_i)`.
  - `in_ready_o = adv && !clear_i && rst_ni`.
  - When `adv`=0, S1, `acc` and the output registers all hold.
- **Saturation:** the internal sum is computed one bit wider. If it exceeds 2^OUTPUT_WIDTH−1, `acc` clamps to all-ones and a sticky `sat` flag is set. The flag is reported on `sat_o` with that vector's result and cleared at vector end.
- **Output handover:** if the output is consumed and a new last beat completes in the same cycle, the output registers reload and `out_valid_o` stays 1.
- **clear_i:** has priority over all other events. It zeroes `s1_valid`, `acc`, `sat` and `out_valid_o`. A beat presented in that cycle is not accepted.
- **Reset (rst_ni=0):** all registers and outputs are 0, including `sum_o`, `bin_o`, `sat_o` and `out_valid_o`; `in_ready_o` is 0. Reset asserted mid-vector discards the partial sum.
- **Zero-beat vectors:** impossible; a vector is at least one beat, the one carrying `last_i`.

## Timing
- Latency: last beat accepted at cycle T → `out_valid_o`=1 at T+2.
- Throughput: one beat per cycle while the output is not stalled.
- `out_valid_o`, `sum_o`, `bin_o` and `sat_o` are registered and stay stable until the handshake completes.
- `in_ready_o` is combinational from `out_valid_o`, `out_ready_i`, `clear_i` and `rst_ni` only. There is no path from `in_valid_i`.
- `out_valid_o` is never withdrawn without a handshake, except by `clear_i` or reset.

## Test plan
Bench parameters: INPUT_WIDTH=8, NUM_BEATS_MAX=4, OUTPUT_WIDTH=6.
1. **Single beat, plain count:** `data_i`=8'hB5, `xnor_en_i`=0, `last_i`=1, `threshold_i`=5, `out_ready_i`=1 → 2 cycles later `sum_o`=5, `bin_o`=1, `sat_o`=0, one-cycle `out_valid_o`.
2. **Three-beat XNOR vector:**
   - Stimulus: data/weight pairs 8'hFF/8'hFF, 8'h00/8'hFF, 8'hF0/8'h0F (last), `threshold_i`=9.
   - Response: `sum_o`=8, `bin_o`=0.
   - Then a second vector back-to-back is accepted with no bubble.
3. **Backpressure:**
   - Stimulus: `out_ready_i`=0 while the result is valid and a new vector is streaming in.
   - Response: `in_ready_o`=0, and `sum_o`/`out_valid_o` are held stable.
   - Then raise `out_ready_i` → first result consumed, second appears, no beat lost or duplicated.
4. **Saturation:** 6 beats of 8'hFF, last on the 6th (total 48 ≤ 63) → `sum_o`=48, `sat_o`=0. Then 8 beats of 8'hFF (total 64) → `sum_o`=63, `sat_o`=1, and the next vector reports `sat_o`=0.
5. **Clear mid-vector:** 2 beats of 8'hFF, then `clear_i` for 1 cycle, then 1 beat of 8'h01 with last → `sum_o`=1. `in_ready_o`=0 during the clear cycle.
6. **Reset mid-operation:** `rst_ni`=0 while `out_valid_o`=1 → next cycle all outputs are 0. After release, a 1-beat vector of 8'h03 gives `sum_o`=2.
